datamover_tcdm_responder: RTL and testbench

DATAMOVER_TCDM_RESPONDER -- requirements
Module: datamover_tcdm_responder

---
 rtl/datamover_tcdm_responder.sv | 125 ++++++++++++
 tb/tb_datamover_tcdm_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/datamover_tcdm_responder.sv
// Multi-bank word-interleaved TCDM responder for datamover master ports.
// Per-bank round-robin arbitration, single-cycle access, one-cycle response latency.
module datamover_tcdm_responder #(
  parameter int unsigned MP         = 4,
  parameter int unsigned NB         = 8,
  parameter int unsigned BANK_WORDS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [MP-1:0]        tcdm_req,
  output logic [MP-1:0]        tcdm_gnt,
  input  logic [MP-1:0][31:0]  tcdm_add,
  input  logic [MP-1:0]        tcdm_wen,
  input  logic [MP-1:0][3:0]   tcdm_be,
  input  logic [MP-1:0][31:0]  tcdm_data,
  output logic [MP-1:0][31:0]  tcdm_r_data,
  output logic [MP-1:0]        tcdm_r_valid
);

  localparam int unsigned NbBits  = $clog2(NB);
  localparam int unsigned RowBits = $clog2(BANK_WORDS);
  localparam int unsigned PortW   = (MP > 1) ? $clog2(MP) : 1;

  logic [NbBits-1:0]  port_bank [MP];
  logic [RowBits-1:0] port_row  [MP];

  logic [NB-1:0]      bank_gnt;
  logic [PortW-1:0]   bank_win  [NB];
  logic [PortW-1:0]   ptr_q     [NB];
  logic [PortW-1:0]   ptr_d     [NB];

  logic [NB-1:0]      bank_we;
  logic [RowBits-1:0] bank_row  [NB];
  logic [3:0]         bank_be   [NB];
  logic [31:0]        bank_wdata[NB];

  // Memory is intentionally never reset.
  logic [31:0]        mem_q [NB][BANK_WORDS];

  logic [MP-1:0]       gnt;
  logic [MP-1:0]       r_valid_q, r_valid_d;
  logic [MP-1:0][31:0] r_data_q, r_data_d;

  // Offset and upper address bits are ignored, so accesses wrap over the memory span.
  logic unused_add;
  assign unused_add = ^tcdm_add;

  always_comb begin : p_decode
    for (int i = 0; i < MP; i++) begin
      port_bank[i] = tcdm_add[i][2 +: NbBits];
      port_row[i]  = tcdm_add[i][2 + NbBits +: RowBits];
    end
  end

  always_comb begin : p_arb
    int unsigned      cand;
    logic [PortW-1:0] idx;
    cand = 0;
    idx  = '0;
    for (int b = 0; b < NB; b++) begin
      bank_gnt[b] = 1'b0;
      bank_win[b] = '0;
      ptr_d[b]    = ptr_q[b];
      // Scan ports starting at the pointer; the first matching requester wins.
      for (int unsigned k = 0; k < MP; k++) begin
        cand = 32'(ptr_q[b]) + k;
        if (cand >= MP) cand = cand - MP;
        idx = PortW'(cand);
        if (rst_ni && !bank_gnt[b] && tcdm_req[idx] && (port_bank[idx] == NbBits'(b))) begin
          bank_gnt[b] = 1'b1;
          bank_win[b] = idx;
        end
      end
      if (bank_gnt[b]) begin
        ptr_d[b] = (bank_win[b] == PortW'(MP - 1)) ? '0 : bank_win[b] + 1'b1;
      end
    end
  end

  always_comb begin : p_bank_wr
    for (int b = 0; b < NB; b++) begin
      bank_we[b]    = bank_gnt[b] && !tcdm_wen[bank_win[b]];
      bank_row[b]   = port_row[bank_win[b]];
      bank_be[b]    = tcdm_be[bank_win[b]];
      bank_wdata[b] = tcdm_data[bank_win[b]];
    end
  end

  // A read sees any write committed at the previous edge, so back-to-back RAW is coherent.
  always_comb begin : p_resp
    for (int i = 0; i < MP; i++) begin
      gnt[i]       = tcdm_req[i] && bank_gnt[port_bank[i]] &&
                     (bank_win[port_bank[i]] == PortW'(i));
      r_valid_d[i] = gnt[i];
      r_data_d[i]  = (gnt[i] && tcdm_wen[i]) ? mem_q[port_bank[i]][port_row[i]] : 32'h0;
    end
  end

  always_ff @(posedge clk_i) begin : p_mem
    for (int b = 0; b < NB; b++) begin
      if (bank_we[b]) begin
        for (int j = 0; j < 4; j++) begin
          if (bank_be[b][j]) mem_q[b][bank_row[b]][8*j +: 8] <= bank_wdata[b][8*j +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : p_state
    if (!rst_ni) begin
      for (int b = 0; b < NB; b++) ptr_q[b] <= '0;
      r_valid_q <= '0;
      r_data_q  <= '0;
    end else begin
      for (int b = 0; b < NB; b++) ptr_q[b] <= ptr_d[b];
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
    end
  end

  assign tcdm_gnt     = gnt;
  assign tcdm_r_valid = r_valid_q;
  assign tcdm_r_data  = r_data_q;

endmodule

// File: tb/tb_datamover_tcdm_responder.sv
// Directed self-checking bench for datamover_tcdm_responder (default parameters).
module tb_datamover_tcdm_responder;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic [3:0]       req, wen, gnt, rvalid;
  logic [3:0][31:0] add, wdata, rdata;
  logic [3:0][3:0]  be;
  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  datamover_tcdm_responder dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .tcdm_req    (req),
    .tcdm_gnt    (gnt),
    .tcdm_add    (add),
    .tcdm_wen    (wen),
    .tcdm_be     (be),
    .tcdm_data   (wdata),
    .tcdm_r_data (rdata),
    .tcdm_r_valid(rvalid)
  );

  task automatic idle();
    req = '0; wen = '1; add = '0; be = '0; wdata = '0;
  endtask

  task automatic set_port(input logic [1:0] p, input logic w_n, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] d);
    req[p] = 1'b1; wen[p] = w_n; add[p] = a; be[p] = b; wdata[p] = d;
  endtask

  // Inputs are driven 2 time units after a rising edge; outputs sampled 2 units later.
  task automatic next_cycle();
    @(posedge clk_i);
    #2;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle();
    next_cycle();
    next_cycle();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    req = '1;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL reset_rvalid: got %b want 0000", rvalid); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    next_cycle();
    next_cycle();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt_clocked: got %b want 0000", gnt); end
    idle();
    rst_ni = 1'b1;
  endtask

  task automatic test_single_rw();
    idle(); set_port(0, 1'b0, 32'h40, 4'hF, 32'hDEADBEEF);
    settle();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_wr_gnt: got %b want 0001", gnt); end
    next_cycle();
    checks++; if (rvalid !== 4'b0001) begin errors++; $display("FAIL single_wr_rvalid: got %b want 0001", rvalid); end
    checks++; if (rdata[0] !== 32'h0) begin errors++; $display("FAIL single_wr_rdata: got %h want 0", rdata[0]); end
    idle(); set_port(0, 1'b1, 32'h40, 4'h0, 32'h0);
    settle();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_rd_gnt: got %b want 0001", gnt); end
    next_cycle();
    checks++; if (rvalid !== 4'b0001) begin errors++; $display("FAIL single_rd_rvalid: got %b want 0001", rvalid); end
    checks++; if (rdata[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rd_data: got %h want deadbeef", rdata[0]); end
    idle();
    next_cycle();
    checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL single_idle_rvalid: got %b want 0000", rvalid); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL single_idle_rdata: got %h want 0", rdata); end
  endtask

  task automatic test_byte_en();
    idle(); set_port(3, 1'b0, 32'h10, 4'hF, 32'h11223344);
    next_cycle();
    idle(); set_port(3, 1'b0, 32'h10, 4'b0101, 32'hAABBCCDD);
    next_cycle();
    idle(); set_port(3, 1'b1, 32'h10, 4'h0, 32'h0);
    next_cycle();
    checks++; if (rdata[3] !== 32'h11BB33DD) begin errors++; $display("FAIL byte_en_data: got %h want 11bb33dd", rdata[3]); end
    idle(); set_port(3, 1'b0, 32'h10, 4'b0000, 32'hFFFFFFFF);
    settle();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL be_zero_gnt: got %b want 1000", gnt); end
    next_cycle();
    checks++; if (rvalid !== 4'b1000) begin errors++; $display("FAIL be_zero_rvalid: got %b want 1000", rvalid); end
    idle(); set_port(3, 1'b1, 32'h10, 4'h0, 32'h0);
    next_cycle();
    checks++; if (rdata[3] !== 32'h11BB33DD) begin errors++; $display("FAIL be_zero_data: got %h want 11bb33dd", rdata[3]); end
    idle();
    next_cycle();
  endtask

  task automatic test_conflict();
    logic [3:0] exp_g;
    logic [3:0] prev_g;
    do_reset();
    prev_g = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      idle();
      for (int p = 0; p < 4; p++) set_port(2'(p), 1'b0, 32'h0, 4'hF, 32'hC0DE0000 | 32'(p));
      exp_g = 4'b0001 << (c % 4);
      settle();
      checks++; if (gnt !== exp_g) begin errors++; $display("FAIL conflict_gnt%0d: got %b want %b", c, gnt, exp_g); end
      next_cycle();
      checks++; if (rvalid !== exp_g) begin errors++; $display("FAIL conflict_rvalid%0d: got %b want %b", c, rvalid, exp_g); end
      prev_g = exp_g;
    end
    idle(); set_port(3, 1'b1, 32'h0, 4'h0, 32'h0);
    settle();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL conflict_rd_gnt: got %b want 1000", gnt); end
    next_cycle();
    checks++; if (rdata[3] !== 32'hC0DE0000) begin errors++; $display("FAIL conflict_last_writer: got %h want c0de0000", rdata[3]); end
    idle();
    next_cycle();
    checks++; if (rvalid !== 4'b0000 || prev_g !== 4'b0001) begin errors++; $display("FAIL conflict_tail: got %b want 0000", rvalid); end
  endtask

  task automatic test_parallel();
    idle();
    for (int p = 0; p < 4; p++) set_port(2'(p), 1'b0, 32'(p * 4), 4'hF, 32'h50000000 + 32'(p));
    settle();
    checks++; if (gnt !== 4'b1111) begin errors++; $display("FAIL parallel_wr_gnt: got %b want 1111", gnt); end
    next_cycle();
    checks++; if (rvalid !== 4'b1111) begin errors++; $display("FAIL parallel_wr_rvalid: got %b want 1111", rvalid); end
    wen = 4'b1111;
    settle();
    checks++; if (gnt !== 4'b1111) begin errors++; $display("FAIL parallel_rd_gnt: got %b want 1111", gnt); end
    next_cycle();
    checks++; if (rvalid !== 4'b1111) begin errors++; $display("FAIL parallel_rd_rvalid: got %b want 1111", rvalid); end
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (rdata[p] !== 32'h50000000 + 32'(p)) begin
        errors++; $display("FAIL parallel_rd_data%0d: got %h want %h", p, rdata[p], 32'h50000000 + 32'(p));
      end
    end
    // Bank 1 pointer is now 2: ports 0 and 2 contend, port 2 wins first, then port 0.
    idle();
    set_port(0, 1'b1, 32'h04, 4'h0, 32'h0);
    set_port(1, 1'b1, 32'h08, 4'h0, 32'h0);
    set_port(2, 1'b1, 32'h24, 4'h0, 32'h0);
    set_port(3, 1'b1, 32'h0C, 4'h0, 32'h0);
    settle();
    checks++; if (gnt !== 4'b1110) begin errors++; $display("FAIL mixed_gnt0: got %b want 1110", gnt); end
    next_cycle();
    settle();
    checks++; if (gnt !== 4'b1011) begin errors++; $display("FAIL mixed_gnt1: got %b want 1011", gnt); end
    next_cycle();
    idle();
    next_cycle();
  endtask

  task automatic test_wrap();
    idle(); set_port(1, 1'b0, 32'h2000, 4'hF, 32'h00001234);
    settle();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL wrap_wr_gnt: got %b want 0010", gnt); end
    next_cycle();
    idle(); set_port(2, 1'b1, 32'h0, 4'h0, 32'h0);
    settle();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL wrap_rd_gnt: got %b want 0100", gnt); end
    next_cycle();
    checks++; if (rdata[2] !== 32'h00001234) begin errors++; $display("FAIL wrap_data: got %h want 00001234", rdata[2]); end
    idle();
    next_cycle();
  endtask

  task automatic test_reset_mid();
    idle(); set_port(2, 1'b1, 32'h0, 4'h0, 32'h0);
    settle();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL rmid_gnt: got %b want 0100", gnt); end
    next_cycle();
    rst_ni = 1'b0;
    settle();
    checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL rmid_rvalid: got %b want 0000", rvalid); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL rmid_rdata: got %h want 0", rdata); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rmid_gnt_in_reset: got %b want 0000", gnt); end
    next_cycle();
    idle();
    rst_ni = 1'b1;
    next_cycle();
    checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL rmid_post_rvalid: got %b want 0000", rvalid); end
    for (int p = 0; p < 4; p++) set_port(2'(p), 1'b1, 32'h0, 4'h0, 32'h0);
    settle();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rmid_post_gnt: got %b want 0001", gnt); end
    next_cycle();
    idle();
    next_cycle();
  endtask

  initial begin
    test_reset();
    next_cycle();
    test_single_rw();
    test_byte_en();
    test_conflict();
    test_parallel();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
